wb_hb_arbiter: RTL
==================

// Module: wb_hb_arbiter
// PURPOSE
//   Round-robin arbiter sharing one Wishbone slave bus between NUM_MASTERS masters.
//   Master 0 is the hostbus-to-Wishbone bridge. Other masters are on-chip engines.
//   Ownership is locked for a whole Wishbone cycle (m_cyc high).
//   A watchdog aborts a transaction when the slave never acks.
// PARAMETERS
//   NUM_MASTERS  2    number of requesting masters (>=2)
//   ADDR_W       16   Wishbone address width
//   DATA_W       16   Wishbone data width
//   TIMEOUT      255  max cycles with s_stb high and no s_ack before abort; 0 = watchdog disabled
// PORTS
//   clk        in   1               system clock, rising edge
//   rst        in   1               asynchronous reset, active-low
//   m_cyc      in   NUM_MASTERS     per-master cycle request
//   m_stb      in   NUM_MASTERS     per-master strobe
//   m_we       in   NUM_MASTERS     per-master write enable
//   m_addr     in   NUM_MASTERS*ADDR_W   packed addresses; master i at [i*ADDR_W +: ADDR_W]
//   m_wrData   in   NUM_MASTERS*DATA_W   packed write data; same packing
//   m_ack      out  NUM_MASTERS     ack routed to the granted master only
//   m_err      out  NUM_MASTERS     one-cycle watchdog abort pulse to the granted master
//   m_rdData   out  DATA_W          s_rdData broadcast to all masters
//   grant      out  NUM_MASTERS     one-hot current owner; all-zero when no owner
//   s_cyc      out  1               slave cycle
//   s_stb      out  1               slave strobe
//   s_we       out  1               slave write enable
//   s_addr     out  ADDR_W          slave address
//   s_wrData   out  DATA_W          slave write data
//   s_ack      in   1               slave acknowledge
//   s_rdData   in   DATA_W          slave read data
// BEHAVIOUR
//   Reset (rst=0, asynchronous): state=IDLE, grant=0, ptr=0, watchdog=0.
//     All outputs are 0 immediately; this includes the case where reset asserts mid-transaction.
//   FSM states: IDLE, BUSY, ABORT.
//   IDLE:
//     - Grant goes to the first i with m_cyc[i]=1, searching from ptr upward with wrap mod NUM_MASTERS.
//     - grant is registered, so s_cyc rises 1 cycle after m_cyc: 1-cycle arbitration latency.
//     - If no m_cyc is set, the arbiter stays in IDLE.
//   BUSY (owner g):
//     - s_cyc/s_stb/s_we/s_addr/s_wrData are combinationally muxed from master g.
//     - m_ack[g] = s_ack & m_stb[g]. m_ack of every other master is 0.
//     - Strobes and requests of non-granted masters are ignored.
//     - m_cyc[g]=0 -> IDLE, ptr = (g+1) mod NUM_MASTERS, grant=0.
//       The bus therefore has at least 1 idle cycle between owners.
//     - An s_ack in the same cycle that m_cyc[g] falls is still delivered to master g.
//   Watchdog:
//     - Counter width is $clog2(TIMEOUT+1).
//     - In BUSY the counter increments each cycle with s_stb=1 and s_ack=0.
//     - It clears on s_ack, when s_stb=0, and on leaving BUSY.
//     - If s_ack arrives in the same cycle the counter would reach TIMEOUT, ack wins and no abort occurs.
//     - On reaching TIMEOUT: m_err[g] pulses for 1 cycle, then state goes to ABORT.
//   ABORT:
//     - s_cyc=s_stb=0 and m_ack=0. s_ack is ignored.
//     - When m_cyc[g]=0 -> IDLE, ptr=(g+1) mod NUM_MASTERS.
//   m_rdData = s_rdData at all times. It is valid to a master only while its m_ack is high.
// TESTING
//   1 Read by master 0, addr 0x0003; slave acks 2 cycles after s_stb with s_rdData=0xAAAA
//     -> s_cyc rises 1 cycle after m_cyc[0]; m_ack[0] high 1 cycle; m_rdData=0xAAAA; m_ack[1]=0.
//   2 Write by master 1, addr 0x0010, data 0xF0F0; master 0 idle
//     -> grant=2'b10; s_we=1, s_addr=0x0010, s_wrData=0xF0F0; m_ack[1] follows s_ack.
//   3 After reset, both masters raise m_cyc in the same cycle
//     -> master 0 granted first; master 1 granted 1 idle cycle after master 0 drops m_cyc.
//     Both request again -> master 0 granted (rotation).
//   4 TIMEOUT=8; master 0 strobes and the slave never acks
//     -> m_err[0] pulses after 8 strobe cycles; s_cyc=0 on the next cycle.
//     -> m_ack[0] never asserts; IDLE reached after m_cyc[0] drops.
//   5 rst=0 while master 1 is in BUSY
//     -> grant and all s_* outputs go to 0 without waiting for clk.
//     After release, both masters request -> master 0 granted (ptr=0).
//   6 Master 0 owns the bus while master 1 toggles m_stb[1] and the slave acks
//     -> m_ack[1] stays 0; s_addr tracks master 0 only.

Source files
------------

// File: rtl/wb_hb_arbiter.sv
// wb_hb_arbiter: round-robin Wishbone arbiter with cycle-long ownership lock
// and a watchdog that aborts a transaction the slave never acknowledges.
module wb_hb_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int TIMEOUT     = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_MASTERS-1:0]        m_cyc,
    input  logic [NUM_MASTERS-1:0]        m_stb,
    input  logic [NUM_MASTERS-1:0]        m_we,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wrData,
    output logic [NUM_MASTERS-1:0]        m_ack,
    output logic [NUM_MASTERS-1:0]        m_err,
    output logic [DATA_W-1:0]             m_rdData,
    output logic [NUM_MASTERS-1:0]        grant,
    output logic                          s_cyc,
    output logic                          s_stb,
    output logic                          s_we,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [DATA_W-1:0]             s_wrData,
    input  logic                          s_ack,
    input  logic [DATA_W-1:0]             s_rdData
);
    localparam int PW = $clog2(NUM_MASTERS);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] WD_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

    state_t                 r_state;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [NUM_MASTERS-1:0] r_err;
    logic [PW-1:0]          r_ptr;
    logic [PW-1:0]          r_g;
    logic [CW-1:0]          r_wd;

    logic [PW-1:0] w_pick;
    logic          w_found;
    logic          w_busy;
    logic          w_own;
    logic          w_hit;
    logic [PW-1:0] w_next;

    always_comb begin
        w_pick  = '0;
        w_found = 1'b0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            if (m_cyc[(int'(r_ptr) + k) % NUM_MASTERS]) begin
                w_found = 1'b1;
                w_pick  = PW'((int'(r_ptr) + k) % NUM_MASTERS);
            end
        end
    end

    assign w_busy   = (r_state == BUSY);
    assign w_own    = |r_grant;
    assign w_next   = (r_g == PW'(NUM_MASTERS - 1)) ? '0 : r_g + 1'b1;
    assign s_cyc    = w_busy & m_cyc[r_g];
    assign s_stb    = w_busy & m_stb[r_g];
    assign s_we     = w_own & m_we[r_g];
    assign s_addr   = w_own ? m_addr[r_g*ADDR_W +: ADDR_W] : '0;
    assign s_wrData = w_own ? m_wrData[r_g*DATA_W +: DATA_W] : '0;
    // Once the abort pulse is out, a late ack must not reach the master.
    assign m_ack    = (w_busy && !(|r_err) && s_ack && m_stb[r_g]) ? r_grant : '0;
    assign m_err    = r_err;
    assign m_rdData = rst ? s_rdData : '0;
    assign grant    = r_grant;
    assign w_hit    = (TIMEOUT != 0) && s_stb && !s_ack && (r_wd == WD_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_err   <= '0;
            r_ptr   <= '0;
            r_g     <= '0;
            r_wd    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state <= BUSY;
                        r_g     <= w_pick;
                        r_grant <= NUM_MASTERS'(1) << w_pick;
                    end
                end
                BUSY: begin
                    if (!m_cyc[r_g]) begin
                        r_state <= IDLE;
                        r_grant <= '0;
                        r_err   <= '0;
                        r_ptr   <= w_next;
                        r_wd    <= '0;
                    end else if (|r_err) begin
                        r_state <= ABORT;
                        r_err   <= '0;
                        r_wd    <= '0;
                    end else if (w_hit) begin
                        r_err   <= r_grant;
                        r_wd    <= r_wd + 1'b1;
                    end else begin
                        r_wd    <= (s_stb && !s_ack) ? r_wd + 1'b1 : '0;
                    end
                end
                ABORT: begin
                    if (!m_cyc[r_g]) begin
                        r_state <= IDLE;
                        r_grant <= '0;
                        r_ptr   <= w_next;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
